mdu_div: RTL and testbench
==========================

Name: mdu_div

Overview:
- Iterative 32-bit radix-2 restoring divider. Executes RV32M DIV, DIVU, REM and REMU.
- Companion to the shift-add multiplier path inside the MDU.
- Uses the same CPU-side handshake: input valid, cpu_busy back-pressure, busy and out_valid.
- Sits beside the multiplier under the MDU top. Result is muxed onto the MDU output when funct3[2]=1.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- div_in_valid  in  1  request strobe from CPU
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 ignored
- div_in_1  in  XLEN  dividend (rs1)
- div_in_2  in  XLEN  divisor (rs2)
- cpu_busy  in  1  CPU cannot consume result this cycle
- div_out  out  XLEN  quotient or remainder
- div_out_valid  out  1  div_out valid
- div_busy  out  1  unit occupied; new requests not accepted

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE; div_out, div_out_valid, div_busy, counter and all datapath registers = 0. Reset mid-operation aborts the operation with no output.
- Accept: at a rising edge where div_in_valid && funct3[2] && !div_busy. At that edge, latch:
  - funct3[1:0] → op_r
  - signed = !funct3[0]
  - |dividend| and |divisor| (absolute values only when signed)
  - quotient-negate flag = signed && (sign1 ^ sign2) && divisor!=0
  - remainder-negate flag = signed && sign1
- Requests with funct3[2]=0, or requests while busy, are ignored with no side effects.
- FSM states IDLE, CALC, DONE; div_busy = (state != IDLE).
  - IDLE → CALC on a normal accept.
  - IDLE → DONE on a special-case accept; the result is registered at the accept edge.
  - CALC: 65-bit {rem, quo} shift register. Per cycle: shift left 1 and trial-subtract the divisor from the upper half. If the result is non-negative, keep the difference and set quo[0]=1; otherwise restore and set quo[0]=0.
  - CALC runs exactly XLEN iterations (counter 0..31). On the 32nd edge go to DONE, registering the sign-fixed result into div_out.
  - DONE: div_out_valid=1 and div_out held stable. Go to IDLE at the first edge where cpu_busy=0 (same-cycle consumption allowed). While cpu_busy=1, stay in DONE indefinitely.
  - IDLE: div_out_valid=0; div_out retains the last value. No accept in the cycle DONE→IDLE; the earliest new accept is the following edge.
- Latency, with accept at edge N:
  - normal op: valid first visible after edge N+32 (33 cycles from request);
  - special case: valid visible after edge N (1 cycle).
- Special cases, decided at accept and skipping CALC:
  - divisor=0: DIV/DIVU → all-ones (0xFFFFFFFF); REM/REMU → dividend unmodified.
  - Signed overflow (DIV/REM with dividend=0x80000000, divisor=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Arithmetic rules:
  - Absolute value of 0x80000000 is handled as unsigned 0x80000000 (a 33-bit-safe subtractor is required).
  - Quotient truncates toward zero.
  - Remainder sign equals dividend sign; a zero remainder is never negated.
  - Unsigned ops use raw operands with no fixups.
- Simultaneous events: div_in_valid while in CALC or DONE is ignored. div_in_valid on the IDLE edge coincident with a reset deassertion is accepted normally.

Test Plan:
- DIVU 100/7, cpu_busy=0 → div_out=14 with valid after exactly 33 cycles; then REMU 100/7 → 2; div_busy high throughout each op.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIV 7/-2 → 0xFFFFFFFD; REM 7/-2 → 1; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; REM -5/0 → 0xFFFFFFFB; each valid 1 cycle after accept.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Also DIVU 0x80000000/0xFFFFFFFF → 0 in 33 cycles.
- Back-pressure: cpu_busy=1 for 4 cycles in DONE while pulsing div_in_valid with new operands → valid and div_out unchanged, request not taken. Drop cpu_busy → IDLE next edge; a subsequent request is accepted.
- rst_n low at CALC iteration 10 → all outputs 0 immediately (async). After release, DIVU 9/3 → 3 with correct 33-cycle latency.

Source files
------------

// File: rtl/mdu_div_if.sv
// CPU-side handshake bundle for the MDU divider: request strobe and operands
// going in, result, result-valid and busy coming back.
interface mdu_div_if #(
  parameter int XLEN = 32
);
  logic            div_in_valid;
  logic [2:0]      funct3;
  logic [XLEN-1:0] div_in_1;
  logic [XLEN-1:0] div_in_2;
  logic            cpu_busy;
  logic [XLEN-1:0] div_out;
  logic            div_out_valid;
  logic            div_busy;

  // CPU side: issues requests and applies back-pressure on the result
  modport master (
    output div_in_valid, funct3, div_in_1, div_in_2, cpu_busy,
    input  div_out, div_out_valid, div_busy
  );

  // Divider side
  modport slave (
    input  div_in_valid, funct3, div_in_1, div_in_2, cpu_busy,
    output div_out, div_out_valid, div_busy
  );
endinterface

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on magnitudes, one quotient bit per cycle, and applies the sign
// fix-up when registering the result. Divide-by-zero and signed overflow
// are resolved at accept time and skip the iteration loop entirely.
module mdu_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  mdu_div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_t            state, state_next;
  logic              op_rem_r;     // 1: remainder result, 0: quotient
  logic              quo_neg_r;
  logic              rem_neg_r;
  logic [XLEN-1:0]   divisor_r;    // divisor magnitude
  logic [2*XLEN-1:0] acc_r;        // {partial remainder, quotient/dividend}
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   div_out_r;

  // Request decode
  logic            accept;
  logic            is_signed;
  logic [XLEN-1:0] abs_1, abs_2;
  logic            div_by_zero, sgn_overflow, special;
  logic [XLEN-1:0] special_result;

  // One restoring step
  logic [XLEN:0]     trial;        // shifted partial remainder, 33-bit safe
  logic              trial_ge;
  logic [XLEN-1:0]   trial_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign accept    = bus.div_in_valid && bus.funct3[2] && (state == IDLE);
  assign is_signed = !bus.funct3[0];

  // Magnitude of 0x80000000 wraps back to 0x80000000, which is correct when
  // read as unsigned -- the datapath treats magnitudes as unsigned.
  assign abs_1 = (is_signed && bus.div_in_1[XLEN-1]) ? -bus.div_in_1 : bus.div_in_1;
  assign abs_2 = (is_signed && bus.div_in_2[XLEN-1]) ? -bus.div_in_2 : bus.div_in_2;

  assign div_by_zero  = (bus.div_in_2 == '0);
  assign sgn_overflow = is_signed && (bus.div_in_1 == MIN_NEG) && (bus.div_in_2 == ALL_ONES);
  assign special      = div_by_zero || sgn_overflow;

  // Architected results for the cases that bypass the iteration loop
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    special_result = '0;
    if (div_by_zero)
      special_result = bus.funct3[1] ? bus.div_in_1 : ALL_ONES;
    else if (sgn_overflow)
      special_result = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // Shift left by one, trial-subtract the divisor, keep or restore
  always_comb begin
    trial      = acc_r[2*XLEN-1:XLEN-1];
    trial_ge   = (trial >= {1'b0, divisor_r});
    trial_diff = trial[XLEN-1:0] - divisor_r;
    acc_next   = {acc_r[2*XLEN-2:0], 1'b0};
    if (trial_ge)
      acc_next = {trial_diff, acc_r[XLEN-2:0], 1'b1};
  end

  // Sign fix-up of the final quotient and remainder; zero is never negated
  always_comb begin
    quo_fix = quo_neg_r ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_fix = acc_next[2*XLEN-1:XLEN];
    if (rem_neg_r && (acc_next[2*XLEN-1:XLEN] != '0))
      rem_fix = -acc_next[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: special cases jump straight to DONE; DONE waits for the CPU
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (cnt_r == LAST_ITER) state_next = DONE;
      DONE: if (!bus.cpu_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing stale behind.
    if (!rst_n) begin
      op_rem_r  <= 1'b0;
      quo_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      divisor_r <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      div_out_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_rem_r  <= bus.funct3[1];
          quo_neg_r <= is_signed && (bus.div_in_1[XLEN-1] ^ bus.div_in_2[XLEN-1]) && !div_by_zero;
          rem_neg_r <= is_signed && bus.div_in_1[XLEN-1];
          divisor_r <= abs_2;
          acc_r     <= {{XLEN{1'b0}}, abs_1};
          cnt_r     <= '0;
          if (special) div_out_r <= special_result;
        end
        CALC: begin
          acc_r <= acc_next;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_ITER) div_out_r <= op_rem_r ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_out       = div_out_r;
  assign bus.div_out_valid = (state == DONE);
  assign bus.div_busy      = (state != IDLE);

endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for mdu_div: a vector table of operations with hand-computed
// results and latencies, plus sequences for back-pressure and mid-op reset.
module tb_mdu_div;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;

  mdu_div_if #(.XLEN(XLEN)) bus ();

  mdu_div #(.XLEN(XLEN), .CNT_W(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [8*14-1:0] name;
    logic [2:0]      f3;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     exp;
    logic [7:0]      lat;   // edges after the accept edge until valid is seen
  } vec_t;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  localparam int N_VEC = 16;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.div_in_valid = 1'b1;
    bus.funct3       = f3;
    bus.div_in_1     = a;
    bus.div_in_2     = b;
    @(posedge clk);
    @(negedge clk);
    bus.div_in_valid = 1'b0;
  endtask

  // Bounded wait for div_out_valid, counting edges and watching div_busy
  task automatic wait_valid(output int k, output logic busy_ok);
    k = 0;
    busy_ok = 1'b1;
    while (!bus.div_out_valid && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (!bus.div_busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   k;
    logic busy_ok;
    issue(f3, a, b);
    check($sformatf("%s busy", name), {31'd0, bus.div_busy}, 32'd1);
    wait_valid(k, busy_ok);
    check($sformatf("%s latency", name), k, lat);
    check($sformatf("%s result", name), bus.div_out, exp);
    check($sformatf("%s busy held", name), {31'd0, busy_ok}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s released", name), {30'd0, bus.div_out_valid, bus.div_busy}, 32'd0);
  endtask

  initial begin
    int   k;
    logic busy_ok;

    vecs[0]  = '{"DIVU 100/7",    F_DIVU, 32'd100,        32'd7,          32'd14,         8'd32};
    vecs[1]  = '{"REMU 100/7",    F_REMU, 32'd100,        32'd7,          32'd2,          8'd32};
    vecs[2]  = '{"DIV -7/2",      F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  8'd32};
    vecs[3]  = '{"REM -7/2",      F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  8'd32};
    vecs[4]  = '{"DIV 7/-2",      F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  8'd32};
    vecs[5]  = '{"REM 7/-2",      F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          8'd32};
    vecs[6]  = '{"DIVU max/1",    F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  8'd32};
    vecs[7]  = '{"DIV 5/0",       F_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  8'd0};
    vecs[8]  = '{"REMU 5/0",      F_REMU, 32'd5,          32'd0,          32'd5,          8'd0};
    vecs[9]  = '{"REM -5/0",      F_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  8'd0};
    vecs[10] = '{"DIV ovf",       F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  8'd0};
    vecs[11] = '{"REM ovf",       F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          8'd0};
    vecs[12] = '{"DIVU min/max",  F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          8'd32};
    vecs[13] = '{"REMU min/max",  F_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  8'd32};
    vecs[14] = '{"DIV min/2",     F_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  8'd32};
    vecs[15] = '{"REM -8/2",      F_REM,  32'hFFFF_FFF8,  32'd2,          32'd0,          8'd32};

    rst_n            = 1'b0;
    bus.div_in_valid = 1'b0;
    bus.funct3       = 3'b000;
    bus.div_in_1     = '0;
    bus.div_in_2     = '0;
    bus.cpu_busy     = 1'b0;

    repeat (2) @(negedge clk);
    check("reset div_out", bus.div_out, 32'd0);
    check("reset valid/busy", {30'd0, bus.div_out_valid, bus.div_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // funct3[2]=0 is not a divider request
    issue(3'b001, 32'd100, 32'd7);
    check("mul funct3 ignored", {30'd0, bus.div_out_valid, bus.div_busy}, 32'd0);

    for (int i = 0; i < N_VEC; i++)
      run_op($sformatf("%0s", vecs[i].name), vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].exp, int'(vecs[i].lat));

    // Back-pressure: result held in DONE, new requests refused
    bus.cpu_busy = 1'b1;
    issue(F_DIVU, 32'd100, 32'd7);
    wait_valid(k, busy_ok);
    check("bp latency", k, 32);
    for (int i = 0; i < 4; i++) begin
      bus.div_in_valid = 1'b1;
      bus.funct3       = F_DIVU;
      bus.div_in_1     = 32'd50 + i;
      bus.div_in_2     = 32'd5;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp hold valid %0d", i), {31'd0, bus.div_out_valid}, 32'd1);
      check($sformatf("bp hold out %0d", i), bus.div_out, 32'd14);
    end
    // Drop cpu_busy with a request still pending: DONE->IDLE edge takes no request
    bus.cpu_busy = 1'b0;
    bus.div_in_1 = 32'd50;
    @(posedge clk);
    @(negedge clk);
    check("bp release idle", {30'd0, bus.div_out_valid, bus.div_busy}, 32'd0);
    check("bp out retained", bus.div_out, 32'd14);
    // Request still high: accepted on the following edge
    @(posedge clk);
    @(negedge clk);
    bus.div_in_valid = 1'b0;
    check("bp next accepted", {31'd0, bus.div_busy}, 32'd1);
    wait_valid(k, busy_ok);
    check("bp next latency", k, 32);
    check("bp next result", bus.div_out, 32'd10);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset in the middle of CALC aborts the operation
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst div_out", bus.div_out, 32'd0);
    check("async rst valid/busy", {30'd0, bus.div_out_valid, bus.div_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("DIVU 9/3", F_DIVU, 32'd9, 32'd3, 32'd3, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
